// File: rtl/serial_shifter.sv
// Iterative RV32I shift unit: one bit position per clock.
// Handles SLL/SRL/SRA behind a start/ready handshake with a registered result.
module serial_shifter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [XLEN-1:0]    value_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [XLEN-1:0]    value_o
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b11;
  localparam logic [1:0] OP_RSV = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    work_q, work_d;
  logic [XLEN-1:0]    value_q, value_d;
  logic [1:0]         op_q, op_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]    shifted;

  always_comb begin
    shifted = work_q;
    unique case (op_q)
      OP_SLL:  shifted = {work_q[XLEN-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, work_q[XLEN-1:1]};
      OP_SRA:  shifted = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: shifted = work_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          work_d = value_i;
          op_d   = op_i;
          cnt_d  = shamt_i;
          if (shamt_i == '0 || op_i == OP_RSV) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Result lands on the edge entering DONE so it is stable while valid_o is high.
    if (state_d == DONE) begin
      value_d = work_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      work_q  <= '0;
      op_q    <= OP_SLL;
      cnt_q   <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign value_o = value_q;

endmodule

// File: tb/tb_serial_shifter.sv
// Directed bench for serial_shifter: vector table plus
// hand-written busy-ignore and mid-operation reset sequences.
module tb_serial_shifter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] value_i;
  logic [4:0]  shamt_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] value_o;

  int total  = 0;
  int passed = 0;

  serial_shifter #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .value_i (value_i),
    .shamt_i (shamt_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .value_o (value_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] val;
    logic [4:0]  sh;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk_i);
    while (!ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("ready_before_start", 32'(ready_o), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [31:0] v, input logic [4:0] sh,
                        input logic [31:0] ev, input int lat);
    int k;
    wait_ready();
    start_i = 1'b1;
    op_i    = op;
    value_i = v;
    shamt_i = sh;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    value_i = ~v;
    shamt_i = ~sh;
    op_i    = 2'b10;
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!valid_o && k < 40);
    check({name, "_latency"}, 32'(k), 32'(lat));
    check({name, "_result"}, value_o, ev);
    check({name, "_busy_in_done"}, 32'(ready_o), 32'd0);
    @(negedge clk_i);
    check({name, "_ready_after"}, 32'(ready_o), 32'd1);
    check({name, "_valid_pulse"}, 32'(valid_o), 32'd0);
    check({name, "_hold"}, value_o, ev);
  endtask

  initial begin
    int k;
    int bad;
    vecs[0]  = '{2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010, 5};
    vecs[1]  = '{2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32};
    vecs[2]  = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 32};
    vecs[3]  = '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
    vecs[4]  = '{2'b10, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF, 1};
    vecs[5]  = '{2'b00, 32'h8000_0001, 5'd31, 32'h8000_0000, 32};
    vecs[6]  = '{2'b11, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 32};
    vecs[7]  = '{2'b11, 32'hF000_0000, 5'd4,  32'hFF00_0000, 5};
    vecs[8]  = '{2'b00, 32'h1234_5678, 5'd8,  32'h3456_7800, 9};
    vecs[9]  = '{2'b11, 32'h8000_0000, 5'd1,  32'hC000_0000, 2};
    vecs[10] = '{2'b01, 32'hFFFF_FFFF, 5'd1,  32'h7FFF_FFFF, 2};
    vecs[11] = '{2'b01, 32'hA5A5_0000, 5'd16, 32'h0000_A5A5, 17};

    rst_i = 1'b1;
    start_i = 1'b0;
    op_i = 2'b00;
    value_i = '0;
    shamt_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_ready", 32'(ready_o), 32'd1);
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_value", value_o, 32'h0);

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].val,
             vecs[i].sh, vecs[i].exp, vecs[i].lat);
    end

    // Busy ignore: start held high with new operands during the shift.
    wait_ready();
    start_i = 1'b1;
    op_i    = 2'b01;
    value_i = 32'hF000_0000;
    shamt_i = 5'd8;
    @(posedge clk_i);
    #1;
    op_i    = 2'b00;
    value_i = 32'h0000_0001;
    shamt_i = 5'd2;
    @(negedge clk_i);
    check("busy_ready_low", 32'(ready_o), 32'd0);
    k = 1;
    while (!valid_o && k < 40) begin
      @(negedge clk_i);
      k++;
    end
    check("busy_first_latency", 32'(k), 32'd9);
    check("busy_first_result", value_o, 32'h00F0_0000);
    @(negedge clk_i);
    check("busy_second_ready", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    #1 start_i = 1'b0;
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!valid_o && k < 40);
    check("busy_second_latency", 32'(k), 32'd3);
    check("busy_second_result", value_o, 32'h0000_0004);

    // Reset while a 20-bit shift is in flight.
    wait_ready();
    start_i = 1'b1;
    op_i    = 2'b00;
    value_i = 32'h0000_0003;
    shamt_i = 5'd20;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_ready", 32'(ready_o), 32'd1);
    check("midrst_value", value_o, 32'h0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (valid_o) bad++;
    end
    check("midrst_no_valid", 32'(bad), 32'd0);
    run_op("post_reset", 2'b00, 32'h0000_0003, 5'd20, 32'h0030_0000, 21);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
